// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 subset core: opcodes, FSM encoding,
// condition-code values and the sign-extension / CC helpers.
package lc3_pkg;

    localparam logic [3:0] OP_BR   = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_LD   = 4'h2;
    localparam logic [3:0] OP_ST   = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_LDR  = 4'h6;
    localparam logic [3:0] OP_STR  = 4'h7;
    localparam logic [3:0] OP_NOT  = 4'h9;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_LEA  = 4'hE;
    localparam logic [3:0] OP_TRAP = 4'hF;

    localparam logic [2:0] NZP_N = 3'b100;
    localparam logic [2:0] NZP_Z = 3'b010;
    localparam logic [2:0] NZP_P = 3'b001;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_FETCH,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_t;

    function automatic logic [15:0] sext5(input logic [4:0] v);
        return {{11{v[4]}}, v};
    endfunction

    function automatic logic [15:0] sext6(input logic [5:0] v);
        return {{10{v[5]}}, v};
    endfunction

    function automatic logic [15:0] sext9(input logic [8:0] v);
        return {{7{v[8]}}, v};
    endfunction

    function automatic logic [2:0] cc_of(input logic [15:0] v);
        if (v[15])
            return NZP_N;
        else if (v == 16'h0000)
            return NZP_Z;
        else
            return NZP_P;
    endfunction

endpackage

// File: rtl/lc3_mem_core_if.sv
// Memory port of the core. A transfer completes on the rising edge where
// mem_req=1 and mem_ack=1; the master holds mem_add/mem_we/mem_out until then.
interface lc3_mem_if;
    logic [15:0] mem_in;
    logic        mem_ack;
    logic        mem_req;
    logic        mem_we;
    logic        mem_fetch;
    logic [15:0] mem_add;
    logic [15:0] mem_out;

    modport master (
        input  mem_in, mem_ack,
        output mem_req, mem_we, mem_fetch, mem_add, mem_out
    );

    modport slave (
        output mem_in, mem_ack,
        input  mem_req, mem_we, mem_fetch, mem_add, mem_out
    );
endinterface

// File: rtl/lc3_regfile.sv
// 8x16 register file: two combinational read ports, one synchronous write
// port, asynchronously cleared.
module lc3_regfile (
    input  logic        clock_in,
    input  logic        reset_in,
    input  logic [2:0]  ra_i,
    input  logic [2:0]  rb_i,
    output logic [15:0] rd_a_o,
    output logic [15:0] rd_b_o,
    input  logic        we_i,
    input  logic [2:0]  wa_i,
    input  logic [15:0] wd_i
);
    logic [15:0] regs_q [8];

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            for (int i = 0; i < 8; i++)
                regs_q[i] <= 16'h0000;
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd_a_o = regs_q[ra_i];
    assign rd_b_o = regs_q[rb_i];
endmodule

// File: rtl/lc3_mem_core.sv
// LC-3 subset core with a req/ack memory port supporting wait states.
// Bus outputs are decoded from registered state only, so reset drops them at once.
module lc3_mem_core
    import lc3_pkg::*;
#(
    parameter logic [15:0] RESET_PC  = 16'h3000,
    parameter int          LED_W     = 8,
    parameter logic [7:0]  TRAP_LED  = 8'h25,
    parameter logic [7:0]  TRAP_HALT = 8'hFF
) (
    input  logic             clock_in,
    input  logic             reset_in,
    lc3_mem_if.master        mem,
    output logic [LED_W-1:0] led_out,
    output logic             halted,
    output state_t           state_o
);
    state_t             state_q, state_d;
    logic [15:0]        pc_q, pc_d;
    logic [15:0]        inst_q, inst_d;
    logic [15:0]        ea_q, ea_d;
    logic [2:0]         nzp_q, nzp_d;
    logic [LED_W-1:0]   led_q, led_d;

    logic        rf_we;
    logic [15:0] rf_wd;
    logic [15:0] rd_a, rd_b;
    logic [2:0]  rb_addr;
    logic [15:0] opnd2;
    logic [3:0]  op;
    logic        is_store;

    assign op       = inst_q[15:12];
    assign is_store = (op == OP_ST) || (op == OP_STR);
    // Port B serves the ALU's second source in EXEC and the store source in MEM.
    assign rb_addr  = (state_q == ST_MEM) ? inst_q[11:9] : inst_q[2:0];
    assign opnd2    = inst_q[5] ? sext5(inst_q[4:0]) : rd_b;

    lc3_regfile u_regfile (
        .clock_in (clock_in),
        .reset_in (reset_in),
        .ra_i     (inst_q[8:6]),
        .rb_i     (rb_addr),
        .rd_a_o   (rd_a),
        .rd_b_o   (rd_b),
        .we_i     (rf_we),
        .wa_i     (inst_q[11:9]),
        .wd_i     (rf_wd)
    );

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q <= ST_INIT;
            pc_q    <= RESET_PC;
            inst_q  <= 16'hFFFF;
            ea_q    <= 16'h0000;
            nzp_q   <= NZP_Z;
            led_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            ea_q    <= ea_d;
            nzp_q   <= nzp_d;
            led_q   <= led_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        inst_d        = inst_q;
        ea_d          = ea_q;
        nzp_d         = nzp_q;
        led_d         = led_q;
        rf_we         = 1'b0;
        rf_wd         = 16'h0000;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.mem_fetch = 1'b0;
        mem.mem_add   = 16'h0000;
        mem.mem_out   = 16'h0000;
        halted        = 1'b0;

        case (state_q)
            ST_INIT: begin
                pc_d    = RESET_PC;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                mem.mem_req   = 1'b1;
                mem.mem_fetch = 1'b1;
                mem.mem_add   = pc_q;
                if (mem.mem_ack) begin
                    inst_d  = mem.mem_in;
                    pc_d    = pc_q + 16'd1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_FETCH;
                case (op)
                    OP_BR: begin
                        if ((inst_q[11:9] & nzp_q) != 3'b000)
                            pc_d = pc_q + sext9(inst_q[8:0]);
                    end
                    OP_ADD: begin
                        rf_we = 1'b1;
                        rf_wd = rd_a + opnd2;
                        nzp_d = cc_of(rd_a + opnd2);
                    end
                    OP_AND: begin
                        rf_we = 1'b1;
                        rf_wd = rd_a & opnd2;
                        nzp_d = cc_of(rd_a & opnd2);
                    end
                    OP_NOT: begin
                        rf_we = 1'b1;
                        rf_wd = ~rd_a;
                        nzp_d = cc_of(~rd_a);
                    end
                    OP_LEA: begin
                        rf_we = 1'b1;
                        rf_wd = pc_q + sext9(inst_q[8:0]);
                        nzp_d = cc_of(pc_q + sext9(inst_q[8:0]));
                    end
                    OP_LD, OP_ST: begin
                        ea_d    = pc_q + sext9(inst_q[8:0]);
                        state_d = ST_MEM;
                    end
                    OP_LDR, OP_STR: begin
                        ea_d    = rd_a + sext6(inst_q[5:0]);
                        state_d = ST_MEM;
                    end
                    OP_JMP: pc_d = rd_a;
                    OP_TRAP: begin
                        if (inst_q[7:0] == TRAP_LED)
                            led_d = led_q + LED_W'(1);
                        if (inst_q[7:0] == TRAP_HALT)
                            state_d = ST_HALT;
                    end
                    default: state_d = ST_HALT;
                endcase
            end
            ST_MEM: begin
                mem.mem_req = 1'b1;
                mem.mem_add = ea_q;
                mem.mem_we  = is_store;
                mem.mem_out = is_store ? rd_b : 16'h0000;
                if (mem.mem_ack) begin
                    if (!is_store) begin
                        rf_we = 1'b1;
                        rf_wd = mem.mem_in;
                        nzp_d = cc_of(mem.mem_in);
                    end
                    state_d = ST_FETCH;
                end
            end
            ST_HALT: halted = 1'b1;
            default: state_d = ST_HALT;
        endcase
    end

    assign led_out = led_q;
    assign state_o = state_q;
endmodule

// File: tb/tb_lc3_mem_core.sv
// Bench for lc3_mem_core: behavioural memory with configurable wait states,
// a write scoreboard, a table of short programs and hand-written sequences.
module tb_lc3_mem_core;
    import lc3_pkg::*;

    logic       clk;
    logic       rst;
    logic [7:0] led;
    logic       hlt;
    state_t     dbg_state;

    lc3_mem_if bus ();

    lc3_mem_core dut (
        .clock_in (clk),
        .reset_in (rst),
        .mem      (bus),
        .led_out  (led),
        .halted   (hlt),
        .state_o  (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model and bookkeeping
    logic [15:0] mem [0:65535];
    assign bus.mem_in = mem[bus.mem_add];

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] data;
        logic        fetch;
        int          cyc;
    } xfer_t;

    xfer_t       log_q[$];
    logic [31:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          wcnt     = 0;
    int          fetch_waits = 0;
    int          data_waits  = 0;
    bit          hang_en  = 0;
    logic [15:0] hang_addr = 16'h0000;
    bit          watch_en = 0;
    logic [15:0] watch_addr = 16'h0000;
    int          watch_cnt = 0;
    int          req_cnt  = 0;
    bit          prev_pend = 0;
    logic [32:0] prev_bus;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic int waits_for(input logic is_fetch, input logic [15:0] a);
        int w;
        w = is_fetch ? fetch_waits : data_waits;
        if (hang_en && a == hang_addr) w = 1000000;
        return w;
    endfunction

    // Responder drives ack at the falling edge; the #1 sample records the transfer
    // that the following rising edge completes.
    initial begin
        bus.mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                bus.mem_ack = 1'b0;
                wcnt = 0;
                prev_pend = 0;
            end else if (bus.mem_req) begin
                if (wcnt >= waits_for(bus.mem_fetch, bus.mem_add)) begin
                    bus.mem_ack = 1'b1;
                end else begin
                    bus.mem_ack = 1'b0;
                    wcnt++;
                end
            end else begin
                bus.mem_ack = 1'b0;
            end
            #1;
            if (!rst && bus.mem_req) begin
                req_cnt++;
                if (watch_en && !bus.mem_fetch && bus.mem_add == watch_addr) watch_cnt++;
                if (prev_pend)
                    check("hold_stable", {15'd0, bus.mem_we, bus.mem_add, bus.mem_out},
                          {15'd0, prev_bus});
                prev_pend = !bus.mem_ack;
                prev_bus  = {bus.mem_we, bus.mem_add, bus.mem_out};
                if (bus.mem_ack) begin
                    log_q.push_back('{bus.mem_add, bus.mem_we, bus.mem_out, bus.mem_fetch, cyc});
                    wcnt = 0;
                    if (bus.mem_we) begin
                        mem[bus.mem_add] = bus.mem_out;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_fail++;
                            $display("FAIL unexpected_write: got %h@%h, expected none",
                                     bus.mem_out, bus.mem_add);
                        end else begin
                            check("write", {bus.mem_add, bus.mem_out}, exp_q.pop_front());
                        end
                    end
                end
            end else begin
                prev_pend = 0;
            end
        end
    end

    // instruction encoders
    function automatic logic [15:0] add_i(input logic [2:0] d, s, input logic [4:0] i);
        return {OP_ADD, d, s, 1'b1, i};
    endfunction
    function automatic logic [15:0] add_r(input logic [2:0] d, s, t);
        return {OP_ADD, d, s, 3'b000, t};
    endfunction
    function automatic logic [15:0] and_i(input logic [2:0] d, s, input logic [4:0] i);
        return {OP_AND, d, s, 1'b1, i};
    endfunction
    function automatic logic [15:0] and_r(input logic [2:0] d, s, t);
        return {OP_AND, d, s, 3'b000, t};
    endfunction
    function automatic logic [15:0] not_r(input logic [2:0] d, s);
        return {OP_NOT, d, s, 6'h3F};
    endfunction
    function automatic logic [15:0] op9(input logic [3:0] o, input logic [2:0] r, input logic [8:0] off);
        return {o, r, off};
    endfunction
    function automatic logic [15:0] ldr(input logic [2:0] d, b, input logic [5:0] off);
        return {OP_LDR, d, b, off};
    endfunction
    function automatic logic [15:0] jmp(input logic [2:0] b);
        return {OP_JMP, 3'b000, b, 6'b000000};
    endfunction
    function automatic logic [15:0] trap(input logic [7:0] v);
        return {OP_TRAP, 4'h0, v};
    endfunction

    task automatic clear_mem();
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #3 rst = 1'b1;
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        log_q.delete();
    endtask

    task automatic run_until_halt(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #2;
            if (hlt) break;
        end
        check({name, "_halted"}, {31'd0, hlt}, 32'd1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
        #2;
    endtask

    typedef struct {
        logic [15:0] i0;
        logic [15:0] i1;
        logic [15:0] i2;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[13];
    int   base, c0;

    initial begin
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_state", {29'd0, dbg_state}, {29'd0, ST_INIT});
        check("rst_bus", {bus.mem_req, bus.mem_we, bus.mem_fetch, bus.mem_add, bus.mem_out},
              32'd0);
        check("rst_led_halt", {23'd0, led, hlt}, 32'd0);
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;

        // Each program ends with ST R1 to x3010 (from x3003) and TRAP xFF.
        vecs[0]  = '{add_i(1, 1, 5'd1), 16'h0000, 16'h0000, 16'h0001};
        vecs[1]  = '{add_i(1, 1, 5'h1F), 16'h0000, 16'h0000, 16'hFFFF};
        vecs[2]  = '{add_i(1, 1, 5'd5), add_i(2, 1, 5'd3), add_r(1, 1, 2), 16'h000D};
        vecs[3]  = '{add_i(1, 1, 5'h1F), not_r(1, 1), 16'h0000, 16'h0000};
        vecs[4]  = '{add_i(1, 1, 5'h0F), add_r(1, 1, 1), and_i(1, 1, 5'h1C), 16'h001C};
        vecs[5]  = '{op9(OP_LEA, 1, 9'h1FF), 16'h0000, 16'h0000, 16'h3000};
        vecs[6]  = '{op9(OP_LD, 1, 9'h01F), 16'h0000, 16'h0000, 16'h5A5A};
        vecs[7]  = '{add_i(1, 1, 5'h10), add_r(1, 1, 1), not_r(1, 1), 16'h001F};
        vecs[8]  = '{add_i(1, 1, 5'd0), op9(OP_BR, 3'b010, 9'd1), add_i(1, 1, 5'd7), 16'h0000};
        vecs[9]  = '{add_i(1, 1, 5'd2), op9(OP_BR, 3'b100, 9'd1), add_i(1, 1, 5'd3), 16'h0005};
        vecs[10] = '{op9(OP_LEA, 2, 9'd2), jmp(2), add_i(1, 1, 5'd9), 16'h0000};
        vecs[11] = '{op9(OP_LEA, 4, 9'h01F), ldr(1, 4, 6'd1), 16'h0000, 16'h1234};
        vecs[12] = '{add_i(1, 1, 5'd12), add_i(2, 2, 5'd10), and_r(1, 1, 2), 16'h0008};

        for (int v = 0; v < 13; v++) begin
            clear_mem();
            mem[16'h3000] = vecs[v].i0;
            mem[16'h3001] = vecs[v].i1;
            mem[16'h3002] = vecs[v].i2;
            mem[16'h3003] = op9(OP_ST, 1, 9'h00C);
            mem[16'h3004] = trap(8'hFF);
            mem[16'h3020] = 16'h5A5A;
            mem[16'h3021] = 16'h1234;
            fetch_waits = $urandom_range(0, 2);
            data_waits  = $urandom_range(0, 2);
            exp_q.push_back({16'h3010, vecs[v].exp});
            do_reset();
            run_until_halt($sformatf("vec%0d", v), 300);
            check($sformatf("vec%0d_drain", v), exp_q.size(), 32'd0);
        end

        // first fetch address and two-cycle / three-cycle timing
        clear_mem();
        fetch_waits = 0;
        data_waits  = 0;
        mem[16'h3000] = 16'h1261;
        mem[16'h3001] = op9(OP_ST, 1, 9'h00E);
        mem[16'h3002] = trap(8'hFF);
        exp_q.push_back({16'h3010, 16'h0001});
        do_reset();
        run_until_halt("basic", 100);
        check("basic_nxfer", log_q.size(), 32'd4);
        if (log_q.size() >= 4) begin
            c0 = log_q[0].cyc;
            check("basic_f0", {log_q[0].fetch, log_q[0].addr}, {1'b1, 16'h3000});
            check("basic_f1", {log_q[1].fetch, log_q[1].addr}, {1'b1, 16'h3001});
            check("basic_f1_cyc", log_q[1].cyc - c0, 32'd2);
            check("basic_wr", {log_q[2].fetch, log_q[2].we, log_q[2].addr}, {2'b01, 16'h3010});
            check("basic_wr_cyc", log_q[2].cyc - c0, 32'd4);
            check("basic_f2_cyc", log_q[3].cyc - c0, 32'd5);
        end

        // counting loop: branch back to x3001 on every pass
        clear_mem();
        mem[16'h3000] = and_i(0, 0, 5'd0);
        mem[16'h3001] = add_i(0, 0, 5'h1F);
        mem[16'h3002] = op9(OP_BR, 3'b100, 9'h1FE);
        do_reset();
        idle(20);
        check("loop_running", {31'd0, hlt}, 32'd0);
        check("loop_enough", {31'd0, log_q.size() >= 8}, 32'd1);
        if (log_q.size() >= 8) begin
            for (int k = 0; k < 8; k++) begin
                base = (k == 0) ? 16'h3000 : ((k % 2 == 1) ? 16'h3001 : 16'h3002);
                check($sformatf("loop_fetch%0d", k), {15'd0, log_q[k].fetch, log_q[k].addr},
                      {15'd0, 1'b1, base[15:0]});
            end
        end

        // LD with three data wait states
        clear_mem();
        data_waits = 3;
        mem[16'h3000] = op9(OP_LD, 2, 9'h00F);
        mem[16'h3001] = op9(OP_ST, 2, 9'h02E);
        mem[16'h3002] = trap(8'hFF);
        mem[16'h3010] = 16'hBEEF;
        exp_q.push_back({16'h3030, 16'hBEEF});
        watch_addr = 16'h3010;
        watch_cnt  = 0;
        watch_en   = 1;
        do_reset();
        run_until_halt("ldwait", 100);
        watch_en = 0;
        check("ldwait_req_cycles", watch_cnt, 32'd4);
        check("ldwait_drain", exp_q.size(), 32'd0);
        if (log_q.size() >= 3)
            check("ldwait_latency", log_q[2].cyc - log_q[0].cyc, 32'd6);
        data_waits = 0;

        // STR with negative offset
        clear_mem();
        mem[16'h3000] = op9(OP_LD, 4, 9'h01F);
        mem[16'h3001] = op9(OP_LD, 3, 9'h01F);
        mem[16'h3002] = 16'h773F;
        mem[16'h3003] = trap(8'hFF);
        mem[16'h3020] = 16'h4000;
        mem[16'h3021] = 16'hABCD;
        exp_q.push_back({16'h3FFF, 16'hABCD});
        do_reset();
        run_until_halt("str", 100);
        check("str_drain", exp_q.size(), 32'd0);

        // LED traps then HALT; no request afterwards
        clear_mem();
        mem[16'h3000] = trap(8'h25);
        mem[16'h3001] = trap(8'h25);
        mem[16'h3002] = trap(8'h30);
        mem[16'h3003] = trap(8'h25);
        mem[16'h3004] = trap(8'hFF);
        do_reset();
        run_until_halt("trap", 100);
        check("trap_led", {24'd0, led}, 32'd3);
        req_cnt = 0;
        idle(20);
        check("trap_no_req", req_cnt, 32'd0);
        check("trap_still_halted", {31'd0, hlt}, 32'd1);

        // unused opcode D halts immediately
        clear_mem();
        mem[16'h3000] = 16'hD000;
        mem[16'h3001] = trap(8'h25);
        do_reset();
        run_until_halt("opd", 50);
        idle(5);
        check("opd_nxfer", log_q.size(), 32'd1);
        check("opd_led", {24'd0, led}, 32'd0);

        // PC wraps from FFFF to 0000
        clear_mem();
        mem[16'h3000] = op9(OP_LD, 5, 9'h01F);
        mem[16'h3001] = jmp(5);
        mem[16'h3020] = 16'hFFFF;
        mem[16'hFFFF] = 16'h1263;
        mem[16'h0000] = trap(8'hFF);
        do_reset();
        run_until_halt("wrap", 100);
        check("wrap_nxfer", log_q.size(), 32'd5);
        if (log_q.size() >= 5) begin
            check("wrap_ffff", {log_q[3].fetch, log_q[3].addr}, {1'b1, 16'hFFFF});
            check("wrap_0000", {log_q[4].fetch, log_q[4].addr}, {1'b1, 16'h0000});
        end

        // reset in the middle of a stalled fetch
        clear_mem();
        mem[16'h3000] = trap(8'h25);
        mem[16'h3001] = trap(8'h25);
        mem[16'h3002] = trap(8'hFF);
        hang_addr = 16'h3001;
        hang_en   = 1;
        do_reset();
        for (int i = 0; i < 50 && log_q.size() < 1; i++) idle(1);
        idle(5);
        check("midrst_pre_led", {24'd0, led}, 32'd1);
        check("midrst_pre_req", {bus.mem_req, bus.mem_add}, {1'b1, 16'h3001});
        #1 rst = 1'b1;
        #1;
        check("midrst_bus", {bus.mem_req, bus.mem_we, bus.mem_fetch, bus.mem_add, bus.mem_out},
              32'd0);
        check("midrst_led_halt", {23'd0, led, hlt}, 32'd0);
        check("midrst_state", {29'd0, dbg_state}, {29'd0, ST_INIT});
        hang_en = 0;
        repeat (2) @(negedge clk);
        #3 rst = 1'b0;
        log_q.delete();
        run_until_halt("midrst", 100);
        if (log_q.size() >= 1)
            check("midrst_refetch", {log_q[0].fetch, log_q[0].addr}, {1'b1, 16'h3000});
        else
            check("midrst_refetch", 32'd0, {15'd0, 1'b1, 16'h3000});
        check("midrst_led", {24'd0, led}, 32'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
